// File: rtl/ifm_pack_writer_32to128.sv
// ---------------------------------------------------------------------------
// ifm_pack_writer_32to128
//   Write-side front end for the 128-bit-wide IFM BRAM. A stream of 32-bit
//   IFM words arrives over a valid/ready handshake. Each group of four
//   consecutive words is packed into one 128-bit line and written to the
//   BRAM, starting at a programmed base line. A trailing partial line is
//   zero-padded and written, and then done pulses for one cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      1-cycle pulse, accepted only when idle; latches base_addr/num_words
//   base_addr  first BRAM line address written
//   num_words  number of 32-bit words in the transfer
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (depends on state only)
//   in_data    IFM word
//   wr_rd_en   BRAM write enable, one pulse per line
//   wr_addr    BRAM line address (holds its value between writes)
//   data_out   packed line for BRAM data_in (holds its value between writes)
//   busy       high from the cycle after start until done
//   done       1-cycle pulse in the cycle after the final line write
// ---------------------------------------------------------------------------
module ifm_pack_writer_32to128 #(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [CNT_W-1:0]      num_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  wr_rd_en,
  output logic [31:0]           wr_addr,
  output logic [32*LANES-1:0]   data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [LANE_W-1:0]     r_lane;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_num;
  logic [31:0]           r_line;
  logic [32*LANES-1:0]   r_pack;
  logic                  r_wr;
  logic [31:0]           r_addr;
  logic [32*LANES-1:0]   r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_final;

  logic                  w_start;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_last;
  logic                  w_lane_full;
  logic                  w_done_d;
  logic [32*LANES-1:0]   w_pack_ins;

  assign w_start     = start && (r_state == S_IDLE);
  assign w_accept    = in_valid && (r_state == S_FILL);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_last      = w_accept && (w_cnt_inc == r_num);
  assign w_lane_full = (r_lane == LANE_W'(LANES - 1));

  // done follows the final line write by one cycle. A zero-length transfer
  // has no write, so it takes its pulse from the DONE state instead.
  assign w_done_d    = r_final || ((r_state == S_DONE) && (r_num == '0));

  // Current pack register with the incoming word dropped into its lane.
  always_comb begin
    w_pack_ins = r_pack;
    w_pack_ins[32*r_lane +: 32] = in_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_words == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_last) begin
          w_state_nxt = w_lane_full ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_line  <= '0;
      r_pack  <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_final <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= 1'b0;
      r_final <= 1'b0;
      r_done  <= w_done_d;

      if (w_start) begin
        r_line <= base_addr;
        r_num  <= num_words;
        r_cnt  <= '0;
        r_lane <= '0;
        r_pack <= '0;
      end

      // A full line or the last word of the transfer closes the line: it is
      // written next cycle (zero-padded if partial) and the pack register
      // restarts empty.
      if (w_accept) begin
        r_cnt   <= w_cnt_inc;
        r_final <= w_last;
        if (w_lane_full || w_last) begin
          r_wr   <= 1'b1;
          r_addr <= r_line;
          r_data <= w_pack_ins;
          r_line <= r_line + 32'd1;
          r_pack <= '0;
          r_lane <= '0;
        end else begin
          r_pack <= w_pack_ins;
          r_lane <= r_lane + LANE_W'(1);
        end
      end

      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_done_d) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign in_ready = (r_state == S_FILL);
  assign wr_rd_en = r_wr;
  assign wr_addr  = r_addr;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
